dsep_stream: RTL and testbench
==============================

Name: dsep_stream

Overview:
- Data separator directly downstream of carrier-frequency-offset compensation.
- Consumes the compensated, gapped sample stream: 8 preamble symbols of 512, then 10 × (32 CP + 512), total 9536 valid samples.
- Tags and routes preamble samples to the preamble/channel-estimation path and strips the cyclic prefix.
- Emits signal and payload symbol samples with symbol/sample indices and SOP/EOP markers for the downstream FFT/RAM logic.

Parameters:
- N_FFT, 512, samples per OFDM symbol
- N_CP, 32, cyclic-prefix samples per data symbol
- N_PRE, 8, preamble symbols per frame
- N_SYM, 10, data symbols per frame (index 0 = signal, 1..9 = payload)
- DW, 12, sample width per I/Q component (signed)

Ports:
- clk  in  1  working clock
- rst_n  in  1  asynchronous reset, active low
- di_re  in  DW  compensated sample, real part
- di_im  in  DW  compensated sample, image part
- di_vld  in  1  sample valid; arbitrary gaps allowed (nominally 1 in 3 clocks)
- clr  in  1  single-cycle pulse: re-arm for next frame from DONE or abort current frame
- pre_re  out  DW  preamble sample, real part
- pre_im  out  DW  preamble sample, image part
- pre_vld  out  1  preamble sample valid
- pre_idx  out  3  preamble symbol index 0..7
- sym_re  out  DW  data sample (CP removed), real part
- sym_im  out  DW  data sample (CP removed), image part
- sym_vld  out  1  data sample valid
- sym_idx  out  4  data symbol index 0..9
- smp_idx  out  9  sample index within symbol 0..511, valid with pre_vld or sym_vld
- sop  out  1  first sample of a symbol (preamble or data), coincident with its valid
- eop  out  1  last sample of a symbol, coincident with its valid
- frame_done  out  1  level; high once all 9536 samples are consumed, until clr/reset

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; all counters 0.
- FSM states: IDLE, PRE, CP, SYM, DONE.
- IDLE → PRE on the first di_vld; that sample is counted.
- All outputs are registered; latency is 1 clock from the di_vld cycle to the corresponding pre_vld/sym_vld.
- Counters advance only on di_vld cycles; gaps hold all state and deassert output valids.
- PRE:
  - Each sample outputs pre_* with pre_idx = symbol counter and smp_idx = sample counter.
  - On sample 511: eop = 1.
  - If pre_idx = N_PRE-1: → CP, sym counter = 0; else pre_idx increments.
- CP:
  - Samples are counted 0..N_CP-1 and discarded; no valid is asserted.
  - On count N_CP-1 → SYM.
- SYM:
  - Each sample outputs sym_*.
  - On sample 511: eop = 1.
  - If sym_idx = N_SYM-1: → DONE; else sym_idx increments and → CP.
- DONE:
  - frame_done = 1; further di_vld is ignored and no outputs are produced.
  - clr → IDLE with frame_done = 0 on the next clock.
- clr in any state:
  - Synchronous abort to IDLE; counters zeroed.
  - Any sample arriving in the clr cycle is dropped, not counted.
  - clr has priority over di_vld.
- sop asserts with smp_idx = 0 of each preamble and data symbol; it never asserts on CP samples.
- pre_vld and sym_vld are mutually exclusive by construction.
- Data paths pass di_re/di_im unmodified; no saturation or arithmetic.
- Counter widths:
  - sample counter 9 bits, wraps 511→0 explicitly;
  - CP counter 5 bits;
  - no free-running overflow is permitted.
- Total counted per frame = N_PRE·N_FFT + N_SYM·(N_CP+N_FFT) = 9536; exactly 4096 pre_vld and 5120 sym_vld pulses.
- Reset mid-frame: immediate return to the IDLE/zero state; the next frame starts at the first di_vld after rst_n deasserts.

Decomposition:
- Shared package dsep_pkg:
  - FSM state enum (IDLE/PRE/CP/SYM/DONE);
  - constants N_FFT, N_CP, N_PRE, N_SYM, FRAME_LEN = 9536;
  - index width localparams.
- No sub-module needed. FSM and counters live in one module; the output register stage is a plain always block.

Test Plan:
- Contiguous frame (di_vld every clock, ramp data 0..9535):
  - 4096 pre_vld, pre_idx steps 0..7;
  - 5120 sym_vld, first sym sample = input #4128;
  - frame_done high 1 clock after sample #9535.
- Gapped frame (di_vld 1 in 3 clocks): identical output sequence to the contiguous case; each output 1 clock after its input; no valids during gaps.
- CP strip check: input value = sample index within the CP+symbol block; every sym_* sample value is ≥32; sop at smp_idx 0 and eop at 511 for all 18 symbols.
- Extra input after DONE: 100 additional di_vld produce no outputs; frame_done stays 1; clr then a new frame restarts with pre_idx 0.
- clr mid-frame (at data symbol 3, sample 200) coincident with di_vld: that sample is dropped; the next di_vld produces pre_vld with pre_idx 0, smp_idx 0, sop 1.
- Asynchronous reset during PRE symbol 5: all outputs 0 immediately; after release, a full frame completes correctly with exact 9536-sample accounting.

Source files
------------

// File: rtl/dsep_pkg.sv
// Shared constants and FSM state type for the post-CFO data separator.
package dsep_pkg;

  localparam int unsigned N_FFT     = 512;
  localparam int unsigned N_CP      = 32;
  localparam int unsigned N_PRE     = 8;
  localparam int unsigned N_SYM     = 10;
  localparam int unsigned FRAME_LEN = N_PRE * N_FFT + N_SYM * (N_CP + N_FFT);

  localparam int unsigned SMP_W = 9;
  localparam int unsigned CP_W  = 5;
  localparam int unsigned PRE_W = 3;
  localparam int unsigned SYM_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    CP,
    SYM,
    DONE
  } state_t;

endpackage

// File: rtl/dsep_stream.sv
// Splits a compensated frame into preamble and CP-stripped data symbols,
// tagging each output sample with symbol/sample indices and SOP/EOP.
module dsep_stream
  import dsep_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_vld,
  input  logic                 clr,
  output logic signed [DW-1:0] pre_re,
  output logic signed [DW-1:0] pre_im,
  output logic                 pre_vld,
  output logic [2:0]           pre_idx,
  output logic signed [DW-1:0] sym_re,
  output logic signed [DW-1:0] sym_im,
  output logic                 sym_vld,
  output logic [3:0]           sym_idx,
  output logic [8:0]           smp_idx,
  output logic                 sop,
  output logic                 eop,
  output logic                 frame_done
);

  state_t           state_q, state_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [CP_W-1:0]  cp_q, cp_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             pre_nx, sym_nx, sop_nx, eop_nx;
  logic             smp_last;

  assign smp_last = (smp_q == SMP_W'(N_FFT - 1));

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    cp_d    = cp_q;
    pre_d   = pre_q;
    sym_d   = sym_q;
    pre_nx  = 1'b0;
    sym_nx  = 1'b0;
    sop_nx  = 1'b0;
    eop_nx  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      smp_d   = '0;
      cp_d    = '0;
      pre_d   = '0;
      sym_d   = '0;
    end else if (di_vld) begin
      case (state_q)
        // IDLE counters are all zero, so the first sample is simply preamble sample 0
        IDLE, PRE: begin
          pre_nx  = 1'b1;
          sop_nx  = (smp_q == '0);
          eop_nx  = smp_last;
          state_d = PRE;
          smp_d   = smp_last ? '0 : smp_q + SMP_W'(1);
          if (smp_last) begin
            if (pre_q == PRE_W'(N_PRE - 1)) begin
              state_d = CP;
              sym_d   = '0;
            end else begin
              pre_d = pre_q + PRE_W'(1);
            end
          end
        end
        CP: begin
          if (cp_q == CP_W'(N_CP - 1)) begin
            cp_d    = '0;
            state_d = SYM;
          end else begin
            cp_d = cp_q + CP_W'(1);
          end
        end
        SYM: begin
          sym_nx = 1'b1;
          sop_nx = (smp_q == '0);
          eop_nx = smp_last;
          smp_d  = smp_last ? '0 : smp_q + SMP_W'(1);
          if (smp_last) begin
            if (sym_q == SYM_W'(N_SYM - 1)) begin
              state_d = DONE;
            end else begin
              sym_d   = sym_q + SYM_W'(1);
              state_d = CP;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      smp_q      <= '0;
      cp_q       <= '0;
      pre_q      <= '0;
      sym_q      <= '0;
      pre_re     <= '0;
      pre_im     <= '0;
      pre_vld    <= 1'b0;
      pre_idx    <= '0;
      sym_re     <= '0;
      sym_im     <= '0;
      sym_vld    <= 1'b0;
      sym_idx    <= '0;
      smp_idx    <= '0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      cp_q       <= cp_d;
      pre_q      <= pre_d;
      sym_q      <= sym_d;
      pre_vld    <= pre_nx;
      sym_vld    <= sym_nx;
      sop        <= sop_nx;
      eop        <= eop_nx;
      frame_done <= (state_d == DONE);
      if (pre_nx) begin
        pre_re  <= di_re;
        pre_im  <= di_im;
        pre_idx <= pre_q;
        smp_idx <= smp_q;
      end
      if (sym_nx) begin
        sym_re  <= di_re;
        sym_im  <= di_im;
        sym_idx <= sym_q;
        smp_idx <= smp_q;
      end
    end
  end

endmodule

// File: tb/tb_dsep_stream.sv
// Self-checking bench for dsep_stream: randomized framing/gaps against an
// arithmetic model of the frame layout (preamble, then CP+symbol blocks).
module tb_dsep_stream;

  localparam int PRE_LEN = 8 * 512;
  localparam int BLK_LEN = 32 + 512;
  localparam int TOTAL   = PRE_LEN + 10 * BLK_LEN;

  typedef logic [68:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] di_re = '0;
  logic [11:0] di_im = '0;
  logic        di_vld = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] pre_re, pre_im, sym_re, sym_im;
  logic        pre_vld, sym_vld, sop, eop, frame_done;
  logic [2:0]  pre_idx;
  logic [3:0]  sym_idx;
  logic [8:0]  smp_idx;

  int checks = 0;
  int errors = 0;

  dsep_stream #(.DW(12)) dut (
    .clk(clk), .rst_n(rst_n), .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .clr(clr), .pre_re(pre_re), .pre_im(pre_im), .pre_vld(pre_vld),
    .pre_idx(pre_idx), .sym_re(sym_re), .sym_im(sym_im), .sym_vld(sym_vld),
    .sym_idx(sym_idx), .smp_idx(smp_idx), .sop(sop), .eop(eop),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Expected output for the k-th counted sample of a frame, from frame layout arithmetic.
  function automatic vec_t exp_vec(int k, logic [11:0] re, logic [11:0] im, logic done);
    logic p, s;
    logic [2:0] pi;
    logic [3:0] si;
    logic [8:0] sm;
    int j, o;
    p = 1'b0; s = 1'b0; pi = '0; si = '0; sm = '0;
    if (k < PRE_LEN) begin
      p  = 1'b1;
      pi = 3'(k / 512);
      sm = 9'(k % 512);
    end else begin
      j = k - PRE_LEN;
      o = j % BLK_LEN;
      if (o >= 32) begin
        s  = 1'b1;
        si = 4'(j / BLK_LEN);
        sm = 9'(o - 32);
      end
    end
    return {p, s, (p | s) && (sm == 9'd0), (p | s) && (sm == 9'd511), pi, si, sm,
            p ? {re, im} : 24'd0, s ? {re, im} : 24'd0, done};
  endfunction

  function automatic vec_t obs_vec();
    return {pre_vld, sym_vld, sop, eop,
            pre_vld ? pre_idx : 3'd0, sym_vld ? sym_idx : 4'd0,
            (pre_vld | sym_vld) ? smp_idx : 9'd0,
            pre_vld ? {pre_re, pre_im} : 24'd0,
            sym_vld ? {sym_re, sym_im} : 24'd0, frame_done};
  endfunction

  function automatic logic [85:0] raw_outs();
    return {pre_re, pre_im, pre_vld, pre_idx, sym_re, sym_im, sym_vld, sym_idx,
            smp_idx, sop, eop, frame_done};
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (raw_outs() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h, want 0", raw_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (raw_outs() !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h, want 0", raw_outs());
    end
  endtask

  task automatic test_frame(input int gap_mode, input int data_mode, input bit use_clr,
                            input string name);
    int k = 0, cyc = 0, npre = 0, nsym = 0;
    logic v;
    logic [11:0] re, im;
    logic [31:0] kv;
    vec_t e, o;
    if (use_clr) begin
      clr = 1'b1; di_vld = 1'b1; di_re = 12'($urandom); di_im = 12'($urandom);
      @(posedge clk); #1;
      clr = 1'b0; di_vld = 1'b0;
      checks++;
      if (obs_vec() !== '0) begin
        errors++;
        $display("FAIL %s_clr: got %h, want 0", name, obs_vec());
      end
    end
    while (k < TOTAL && cyc < 60000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      kv = k;
      case (data_mode)
        0: begin re = kv[11:0]; im = ~kv[11:0]; end
        1: begin
          re = (k < PRE_LEN) ? 12'(k % 512) : 12'((k - PRE_LEN) % BLK_LEN);
          im = 12'($urandom);
        end
        default: {re, im} = 24'($urandom);
      endcase
      di_vld = v; di_re = re; di_im = im;
      @(posedge clk); #1;
      e = v ? exp_vec(k, re, im, k == TOTAL - 1) : '0;
      o = obs_vec();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s k=%0d cyc=%0d: got %h, want %h", name, k, cyc, o, e);
      end
      if (pre_vld) npre++;
      if (sym_vld) nsym++;
      if (data_mode == 1 && sym_vld) begin
        checks++;
        if (sym_re < 12'd32) begin
          errors++;
          $display("FAIL %s_cp_strip k=%0d: got sym_re %0d, want >=32", name, k, sym_re);
        end
      end
      if (v) k++;
      cyc++;
    end
    di_vld = 1'b0;
    checks++;
    if (k != TOTAL) begin
      errors++;
      $display("FAIL %s_budget: got %0d samples, want %0d", name, k, TOTAL);
    end
    checks++;
    if (npre != 4096) begin
      errors++;
      $display("FAIL %s_pre_count: got %0d, want 4096", name, npre);
    end
    checks++;
    if (nsym != 5120) begin
      errors++;
      $display("FAIL %s_sym_count: got %0d, want 5120", name, nsym);
    end
    @(posedge clk); #1;
    checks++;
    if (obs_vec() !== 69'd1) begin
      errors++;
      $display("FAIL %s_done_hold: got %h, want 1", name, obs_vec());
    end
  endtask

  task automatic test_after_done();
    logic [11:0] re, im;
    repeat (100) begin
      di_vld = 1'b1; di_re = 12'($urandom); di_im = 12'($urandom);
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== 69'd1) begin
        errors++;
        $display("FAIL after_done: got %h, want 1", obs_vec());
      end
    end
    di_vld = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL done_clr: got %h, want 0", obs_vec());
    end
    re = 12'($urandom); im = 12'($urandom);
    di_vld = 1'b1; di_re = re; di_im = im;
    @(posedge clk); #1;
    di_vld = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec(0, re, im, 1'b0)) begin
      errors++;
      $display("FAIL restart_first: got %h, want %h", obs_vec(), exp_vec(0, re, im, 1'b0));
    end
  endtask

  task automatic test_clr_mid();
    int target = PRE_LEN + 3 * BLK_LEN + 32 + 200;
    logic [11:0] re, im;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < target; k++) begin
      re = 12'($urandom); im = 12'($urandom);
      di_vld = 1'b1; di_re = re; di_im = im;
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec(k, re, im, 1'b0)) begin
        errors++;
        $display("FAIL clr_mid_pre k=%0d: got %h, want %h", k, obs_vec(), exp_vec(k, re, im, 1'b0));
      end
    end
    clr = 1'b1; di_re = 12'($urandom);
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL clr_mid_drop: got %h, want 0", obs_vec());
    end
    re = 12'($urandom); im = 12'($urandom);
    di_re = re; di_im = im;
    @(posedge clk); #1;
    di_vld = 1'b0;
    checks++;
    if (obs_vec() !== exp_vec(0, re, im, 1'b0)) begin
      errors++;
      $display("FAIL clr_mid_restart: got %h, want %h", obs_vec(), exp_vec(0, re, im, 1'b0));
    end
  endtask

  task automatic test_async_reset();
    int target = 5 * 512 + 100;
    logic [11:0] re, im;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < target; k++) begin
      re = 12'($urandom); im = 12'($urandom);
      di_vld = 1'b1; di_re = re; di_im = im;
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== exp_vec(k, re, im, 1'b0)) begin
        errors++;
        $display("FAIL arst_pre k=%0d: got %h, want %h", k, obs_vec(), exp_vec(k, re, im, 1'b0));
      end
    end
    di_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (raw_outs() !== '0) begin
      errors++;
      $display("FAIL arst_immediate: got %h, want 0", raw_outs());
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    test_frame(0, 2, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_frame(0, 0, 1'b1, "contig");
    test_after_done();
    test_frame(1, 0, 1'b1, "gap3");
    test_frame(2, 1, 1'b1, "cpstrip");
    test_clr_mid();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
